// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, owner encoding, width defaults.
// No logic; imported by the arbiter, its grant sub-module and the bus interface.
package mem_arb_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and shared-memory handshakes around the arbiter.
// master = arbiter side, slave = requesters plus memory.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way grant: one-hot grant (bit0 = IFU, bit1 = LSU), purely combinational.
// Tie-break is fixed LSU priority, or alternating when ARB_ROUND_ROBIN_EN is defined.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       req_ifu,
    input  logic       req_lsu,
`ifdef ARB_ROUND_ROBIN_EN
    input  owner_t     last_grant,
`endif
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        if (req_ifu && req_lsu) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant = (last_grant == OWN_LSU) ? 2'b01 : 2'b10;
`else
            grant = 2'b10;
`endif
        end else if (req_lsu) begin
            grant = 2'b10;
        end else if (req_ifu) begin
            grant = 2'b01;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction in flight.
// Accept-to-resp_valid is 3 cycles minimum; memory stalls hold ISSUE/WAIT, no new grant meanwhile.
// Optional ARB_ROUND_ROBIN_EN: alternating tie-break instead of fixed LSU priority.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    state_t            state_q, state_d;
    owner_t            owner_q;
    logic [1:0]        grant;
    logic              latch;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [DATA_W-1:0] ifu_rdata_q, lsu_rdata_q;
    logic              ifu_resp_q, lsu_resp_q;
    logic              resp_done;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_q;
`endif

    rr_arbiter2 u_arb (
        .req_ifu    (bus.ifu_req_valid),
        .req_lsu    (bus.lsu_req_valid),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant (last_q),
`endif
        .grant      (grant)
    );

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    latch   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE:   if (bus.mem_req_ready)  state_d = WAIT;
            WAIT:    if (bus.mem_resp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign resp_done = (state_q == WAIT) && bus.mem_resp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // IFU transactions are always reads: write fields forced to zero when latched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (latch) begin
            if (grant[1]) begin
                owner_q <= OWN_LSU;
                addr_q  <= bus.lsu_addr;
                wen_q   <= bus.lsu_wen;
                wdata_q <= bus.lsu_wdata;
                wmask_q <= bus.lsu_wmask;
            end else begin
                owner_q <= OWN_IFU;
                addr_q  <= bus.ifu_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifu_resp_q  <= 1'b0;
            lsu_resp_q  <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            ifu_resp_q <= resp_done && (owner_q == OWN_IFU);
            lsu_resp_q <= resp_done && (owner_q == OWN_LSU);
            if (resp_done && owner_q == OWN_IFU) ifu_rdata_q <= bus.mem_rdata;
            if (resp_done && owner_q == OWN_LSU) lsu_rdata_q <= wen_q ? '0 : bus.mem_rdata;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        last_q <= OWN_LSU;
        else if (latch) last_q <= grant[1] ? OWN_LSU : OWN_IFU;
    end
`endif

    // Readies are combinational from the grant; rst masks them without waiting for an edge.
    assign bus.ifu_req_ready  = latch && grant[0] && !rst;
    assign bus.lsu_req_ready  = latch && grant[1] && !rst;
    assign bus.ifu_resp_valid = ifu_resp_q;
    assign bus.lsu_resp_valid = lsu_resp_q;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.lsu_rdata      = lsu_rdata_q;
    assign bus.mem_req_valid  = (state_q == ISSUE);
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wen        = wen_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_wmask      = wmask_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle, plus directed scenarios.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    mem_arbiter_if bus ();

    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int vec = 0;
    int bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // 0 = none, 1 = IFU, 2 = LSU
    function automatic int pick(input bit iv, input bit lv, input int last);
        if (iv && lv) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (last == 2) ? 1 : 2;
`else
            return 2;
`endif
        end
        if (lv) return 2;
        if (iv) return 1;
        return 0;
    endfunction

    // Memory responder knobs, sampled on the falling edge
    bit          hold_ready = 1'b0;
    bit          auto_resp  = 1'b1;
    bit          stray      = 1'b0;
    logic [31:0] rd_knob    = 32'h0;

    initial begin
        bit take, s, h;
        logic [31:0] rd;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'h0;
        forever begin
            @(negedge clk);
            take = bus.mem_req_valid && bus.mem_req_ready && !rst && auto_resp;
            s    = stray;
            h    = hold_ready;
            rd   = rd_knob;
            @(posedge clk);
            #1;
            bus.mem_req_ready  = !h;
            bus.mem_resp_valid = take || s;
            bus.mem_rdata      = rd;
        end
    end

    // Transaction-level model: pending request, whether memory has taken it, per-requester results
    bit          m_pend, m_sent, m_iresp, m_lresp;
    int          m_own, m_last;
    logic [31:0] m_addr, m_wdata, m_irdata, m_lrdata;
    logic        m_wen;
    logic [7:0]  m_wmask;

    int          n_iresp = 0, n_lresp = 0, acc_cyc = 0, resp_cyc = 0;
    int          grants[$];
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_wen;
    logic [7:0]  cap_wmask;

    always @(negedge clk) begin
        int w;
        cyc++;
        if (rst) begin
            check("rst_ifu_ready", 64'(bus.ifu_req_ready), 64'(0));
            check("rst_lsu_ready", 64'(bus.lsu_req_ready), 64'(0));
            check("rst_ifu_resp", 64'(bus.ifu_resp_valid), 64'(0));
            check("rst_lsu_resp", 64'(bus.lsu_resp_valid), 64'(0));
            check("rst_mem_valid", 64'(bus.mem_req_valid), 64'(0));
            check("rst_ifu_rdata", 64'(bus.ifu_rdata), 64'(0));
            check("rst_lsu_rdata", 64'(bus.lsu_rdata), 64'(0));
            check("rst_mem_fields", {bus.mem_addr, bus.mem_wdata}, 64'(0));
            check("rst_mem_wen_mask", 64'({bus.mem_wen, bus.mem_wmask}), 64'(0));
            m_pend = 0; m_sent = 0; m_iresp = 0; m_lresp = 0; m_own = 1; m_last = 2;
            m_addr = 0; m_wdata = 0; m_wen = 0; m_wmask = 0; m_irdata = 0; m_lrdata = 0;
        end else begin
            w = m_pend ? 0 : pick(bus.ifu_req_valid, bus.lsu_req_valid, m_last);
            check("ifu_req_ready", 64'(bus.ifu_req_ready), 64'(w == 1));
            check("lsu_req_ready", 64'(bus.lsu_req_ready), 64'(w == 2));
            check("mem_req_valid", 64'(bus.mem_req_valid), 64'(m_pend && !m_sent));
            check("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
            check("mem_wen", 64'(bus.mem_wen), 64'(m_wen));
            check("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
            check("mem_wmask", 64'(bus.mem_wmask), 64'(m_wmask));
            check("ifu_resp_valid", 64'(bus.ifu_resp_valid), 64'(m_iresp));
            check("lsu_resp_valid", 64'(bus.lsu_resp_valid), 64'(m_lresp));
            check("ifu_rdata", 64'(bus.ifu_rdata), 64'(m_irdata));
            check("lsu_rdata", 64'(bus.lsu_rdata), 64'(m_lrdata));

            if (bus.ifu_resp_valid) begin n_iresp++; resp_cyc = cyc; end
            if (bus.lsu_resp_valid) begin n_lresp++; resp_cyc = cyc; end
            if (bus.ifu_req_ready || bus.lsu_req_ready) begin
                grants.push_back(bus.lsu_req_ready ? 2 : 1);
                acc_cyc = cyc;
            end
            if (bus.mem_req_valid) begin
                cap_addr = bus.mem_addr; cap_wdata = bus.mem_wdata;
                cap_wen = bus.mem_wen; cap_wmask = bus.mem_wmask;
            end

            m_iresp = 0;
            m_lresp = 0;
            if (m_pend && m_sent && bus.mem_resp_valid) begin
                if (m_own == 1) begin m_iresp = 1; m_irdata = bus.mem_rdata; end
                else begin m_lresp = 1; m_lrdata = m_wen ? 32'h0 : bus.mem_rdata; end
                m_pend = 0;
            end else if (m_pend && !m_sent && bus.mem_req_ready) begin
                m_sent = 1;
            end else if (!m_pend && w != 0) begin
                m_pend = 1; m_sent = 0; m_own = w;
                if (w == 2) begin
                    m_addr = bus.lsu_addr; m_wen = bus.lsu_wen;
                    m_wdata = bus.lsu_wdata; m_wmask = bus.lsu_wmask;
                end else begin
                    m_addr = bus.ifu_addr; m_wen = 0; m_wdata = 0; m_wmask = 0;
                end
`ifdef ARB_ROUND_ROBIN_EN
                m_last = w;
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            #1;
            if (bus.ifu_req_ready || bus.lsu_req_ready) got = 1;
        end
        if (!got) check({name, "_grant_timeout"}, 64'(0), 64'(1));
        step();
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
    endtask

    task automatic wait_resps(input string name, input int target);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            #1;
            if (n_iresp + n_lresp >= target) got = 1;
        end
        if (!got) check({name, "_resp_timeout"}, 64'(n_iresp + n_lresp), 64'(target));
        step();
    endtask

    task automatic set_ifu(input logic [31:0] a);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = a;
    endtask

    task automatic set_lsu(input logic [31:0] a, input logic we, input logic [31:0] d, input logic [7:0] m);
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = a;
        bus.lsu_wen       = we;
        bus.lsu_wdata     = d;
        bus.lsu_wmask     = m;
    endtask

    initial begin
        int exp_g[3];
        int base, ni, nl, ng;
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{1, 2, 1};
`else
        exp_g = '{2, 2, 2};
`endif
        rst = 1'b1;
        bus.ifu_req_valid = 0; bus.ifu_addr = 0;
        bus.lsu_req_valid = 0; bus.lsu_addr = 0; bus.lsu_wen = 0; bus.lsu_wdata = 0; bus.lsu_wmask = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Simultaneous requests, three rounds
        for (int i = 0; i < 3; i++) begin
            rd_knob = 32'h1000 + 32'(i);
            step();
            base = n_iresp + n_lresp;
            ng = grants.size();
            set_ifu(32'h100 + 32'(i));
            set_lsu(32'h200 + 32'(i), 1'b0, 32'h0, 8'h0);
            wait_grant("tie");
            wait_resps("tie", base + 1);
            check($sformatf("tie_grant_%0d", i), 64'(grants[ng]), 64'(exp_g[i]));
        end

        // Fetch alone, immediate memory
        rd_knob = 32'h00000413;
        step();
        base = n_iresp + n_lresp;
        ni = n_iresp;
        set_ifu(32'h80000000);
        wait_grant("ifu");
        wait_resps("ifu", base + 1);
        repeat (3) step();
        check("ifu_rdata_413", 64'(bus.ifu_rdata), 64'(32'h00000413));
        check("ifu_resp_once", 64'(n_iresp - ni), 64'(1));
        check("ifu_latency", 64'(resp_cyc - acc_cyc), 64'(3));
        check("ifu_cap_addr", 64'(cap_addr), 64'(32'h80000000));

        // Store
        base = n_iresp + n_lresp;
        nl = n_lresp;
        set_lsu(32'h80001000, 1'b1, 32'hDEADBEEF, 8'h0F);
        wait_grant("st");
        wait_resps("st", base + 1);
        check("st_addr", 64'(cap_addr), 64'(32'h80001000));
        check("st_wdata", 64'(cap_wdata), 64'(32'hDEADBEEF));
        check("st_wmask", 64'(cap_wmask), 64'(8'h0F));
        check("st_wen", 64'(cap_wen), 64'(1));
        check("st_resp", 64'(n_lresp - nl), 64'(1));
        check("st_rdata_zero", 64'(bus.lsu_rdata), 64'(0));

        // Memory stall for 5 cycles while a fetch waits
        hold_ready = 1'b1;
        step(); step();
        base = n_iresp + n_lresp;
        set_lsu(32'h80002000, 1'b0, 32'h0, 8'h0);
        wait_grant("stall");
        ng = grants.size();
        set_ifu(32'h80003000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("stall_valid", 64'(bus.mem_req_valid), 64'(1));
            check("stall_addr", 64'(bus.mem_addr), 64'(32'h80002000));
        end
        check("stall_no_grant", 64'(grants.size()), 64'(ng));
        step();
        hold_ready = 1'b0;
        wait_grant("stall_ifu");
        wait_resps("stall", base + 2);
        check("stall_grant_order", 64'(grants[ng]), 64'(1));

        // Reset while waiting for the memory response
        auto_resp = 1'b0;
        step(); step();
        ni = n_iresp;
        nl = n_lresp;
        set_lsu(32'h80004000, 1'b0, 32'h0, 8'h0);
        wait_grant("rst");
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        check("rstw_mem_valid", 64'(bus.mem_req_valid), 64'(0));
        check("rstw_lsu_resp", 64'(bus.lsu_resp_valid), 64'(0));
        check("rstw_lsu_rdata", 64'(bus.lsu_rdata), 64'(0));
        check("rstw_mem_addr", 64'(bus.mem_addr), 64'(0));
        step();
        rst = 1'b0;
        auto_resp = 1'b1;

        // Late / stray memory response while idle
        rd_knob = 32'hCAFEF00D;
        stray = 1'b1;
        step();
        stray = 1'b0;
        repeat (4) step();
        check("stray_no_lsu_resp", 64'(n_lresp - nl), 64'(0));
        check("stray_no_ifu_resp", 64'(n_iresp - ni), 64'(0));
        check("stray_ifu_rdata", 64'(bus.ifu_rdata), 64'(0));
        check("stray_lsu_rdata", 64'(bus.lsu_rdata), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 ADDR_W, 32, address width of all address ports.
REQ-002 DATA_W, 32, data width of all data ports.
REQ-003 MASK_W, 8, write byte-mask width; bit i enables byte i.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 ifu_req_valid  in  1  fetch read request.
REQ-008 ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-009 ifu_addr  in  ADDR_W  fetch address.
REQ-010 ifu_resp_valid  out  1  one-cycle fetch completion pulse.
REQ-011 ifu_rdata  out  DATA_W  fetch data, valid with ifu_resp_valid.
REQ-012 lsu_req_valid  in  1  load/store request.
REQ-013 lsu_req_ready  out  1  load/store request accepted this cycle.
REQ-014 lsu_addr  in  ADDR_W  load/store address.
REQ-015 lsu_wen  in  1  1 = store, 0 = load.
REQ-016 lsu_wdata  in  DATA_W  store data.
REQ-017 lsu_wmask  in  MASK_W  store byte mask.
REQ-018 lsu_resp_valid  out  1  one-cycle load/store completion pulse.
REQ-019 lsu_rdata  out  DATA_W  load data, valid with lsu_resp_valid.
REQ-020 mem_req_valid  out  1  request to shared memory port.
REQ-021 mem_req_ready  in  1  memory accepts request.
REQ-022 mem_addr / mem_wen / mem_wdata / mem_wmask  out  ADDR_W/1/DATA_W/MASK_W  latched request fields.
REQ-023 mem_resp_valid  in  1  memory completion.
REQ-024 mem_rdata  in  DATA_W  memory read data.

Function
REQ-025 FSM states IDLE, ISSUE, WAIT; one transaction outstanding at most.
REQ-026 IDLE: if any req_valid, the winner's req_ready is 1 combinationally, fields plus owner are latched at the edge, next state ISSUE; the loser's ready stays 0.
REQ-027 IFU requests are latched with wen=0, wdata=0, wmask=0.
REQ-028 ISSUE: mem_req_valid=1 with fields stable until mem_req_ready=1; then WAIT.
REQ-029 WAIT: on mem_resp_valid, owner's rdata register loads mem_rdata (loads) or 0 (stores), owner's resp_valid pulses high the following cycle, and the state returns to IDLE.
REQ-030 A new grant is legal in the same cycle as a resp_valid pulse; minimum accept-to-resp_valid latency is 3 cycles.
REQ-031 mem_resp_valid outside WAIT is ignored; mem_req_valid is 0 outside ISSUE.
REQ-032 rdata outputs hold their last value between responses; a requester must keep its req_valid and fields stable until ready.
REQ-033 Default policy: LSU has fixed priority over IFU on simultaneous requests.

Reset
REQ-034 rst forces IDLE immediately; all ready/valid outputs go 0; rdata, mem_* fields, and owner go 0; last-grant = LSU.
REQ-035 A transaction in flight at reset is dropped; no resp_valid is issued for it.

Configuration
REQ-036 ARB_ROUND_ROBIN_EN defined: on a tie, grant the requester not granted last, and update last-grant on every grant; without it, use fixed LSU priority and the last-grant register is absent.

Structure
REQ-037 Shared package mem_arb_pkg holds the state encoding, owner encoding (OWN_IFU, OWN_LSU), and width defaults.
REQ-038 The grant logic is sub-module rr_arbiter2 (two requests plus last-grant in, one-hot grant out).

Verification
REQ-039 IFU only, addr 0x80000000, mem_rdata 0x00000413, ready/resp immediate -> ifu_resp_valid pulses once 3 cycles after accept with ifu_rdata 0x00000413.
REQ-040 LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F -> mem fields match exactly, lsu_resp_valid pulses, lsu_rdata 0.
REQ-041 Simultaneous requests, three times each -> default build grants LSU,LSU,LSU; round-robin build grants IFU,LSU,IFU.
REQ-042 mem_req_ready held 0 for 5 cycles -> mem_req_valid and fields stay stable, no second grant.
REQ-043 rst asserted in WAIT -> outputs 0 the same cycle, late mem_resp_valid ignored, no resp_valid.
REQ-044 Stray mem_resp_valid in IDLE -> no resp_valid pulse and no change to the rdata outputs.
